// File: rtl/ntt_stage_controller_if.sv
// Handshake and memory-address bundle between the NTT stage controller and its datapath.
`timescale 1ns/1ps
interface ntt_stage_controller_if #(
  parameter int LOGN = 10
);
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;

  logic            start;
  logic            stall;
  logic            busy;
  logic            done;
  logic [SW-1:0]   stage;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;

  modport master (
    input  start, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_controller.sv
// In-place iterative Cooley-Tukey NTT sequencer: issues butterfly reads, delays their
// addresses to the write-back point, and drains the pipeline between stages.
`timescale 1ns/1ps
module ntt_stage_controller #(
  parameter int LOGN       = 10,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 4
) (
  input logic                   clk,
  input logic                   rstn,
  ntt_stage_controller_if.master bus
);
  localparam int NH = 1 << (LOGN - 1);
  localparam int D  = RD_LATENCY + BF_LATENCY;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam logic [LOGN-2:0] J_LAST = (LOGN-1)'(NH - 1);
  localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   stage_q;
  logic [LOGN-2:0] j;
  logic            busy_q;
  logic            done_q;
  logic            issue;
  logic            pending;
  logic [LOGN-1:0] addr_a_c;
  logic [LOGN-1:0] addr_b_c;
  logic [LOGN-2:0] tw_c;

  logic            vld_p    [D];
  logic [LOGN-1:0] addr_a_p [D];
  logic [LOGN-1:0] addr_b_p [D];

  function automatic logic [LOGN-1:0] half_of(input logic [SW-1:0] s);
    return LOGN'(1) << s;
  endfunction

  // Butterfly j of stage s lives in group g = j>>s at offset k = j mod 2^s.
  function automatic logic [LOGN-1:0] bf_addr_a(input logic [LOGN-2:0] jj,
                                                input logic [SW-1:0]   s);
    logic [LOGN-1:0] jx, k, g;
    jx = {1'b0, jj};
    k  = jx & (half_of(s) - LOGN'(1));
    g  = jx >> s;
    return ((g << s) << 1) | k;
  endfunction

  function automatic logic [LOGN-2:0] bf_tw_addr(input logic [LOGN-2:0] jj,
                                                 input logic [SW-1:0]   s);
    logic [LOGN-1:0] k, t;
    k = {1'b0, jj} & (half_of(s) - LOGN'(1));
    t = k << (LOGN - 1 - int'(s));
    return t[LOGN-2:0];
  endfunction

  assign issue = (state == ISSUE) && !bus.stall;

  always_comb begin
    addr_a_c = '0;
    addr_b_c = '0;
    tw_c     = '0;
    if (issue) begin
      addr_a_c = bf_addr_a(j, stage_q);
      addr_b_c = addr_a_c + half_of(stage_q);
      tw_c     = bf_tw_addr(j, stage_q);
    end
  end

  // Anything still in flight other than the write happening this cycle blocks the next stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < D - 1; i++) pending = pending | vld_p[i];
  end

  // Read issue -> write-back delay line (stage p0 is one cycle after issue)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_a_p[0] <= addr_a_c;
    addr_b_p[0] <= addr_b_c;
    for (int i = 1; i < D; i++) begin
      addr_a_p[i] <= addr_a_p[i-1];
      addr_b_p[i] <= addr_b_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      stage_q <= '0;
      j       <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ISSUE;
            stage_q <= '0;
            j       <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (!bus.stall) begin
            if (j == J_LAST) begin
              state <= DRAIN;
              j     <= '0;
            end else begin
              j <= j + (LOGN-1)'(1);
            end
          end
        end
        DRAIN: begin
          if (!pending) begin
            if (stage_q == S_LAST) begin
              state   <= DONE;
              stage_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state   <= ISSUE;
              stage_q <= stage_q + SW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = issue;
  assign bus.rd_addr_a = addr_a_c;
  assign bus.rd_addr_b = addr_b_c;
  assign bus.tw_addr   = tw_c;
  assign bus.wr_en     = vld_p[D-1];
  assign bus.wr_addr_a = vld_p[D-1] ? addr_a_p[D-1] : '0;
  assign bus.wr_addr_b = vld_p[D-1] ? addr_b_p[D-1] : '0;
endmodule

// File: tb/tb_ntt_stage_controller.sv
// Bench for ntt_stage_controller: cycle schedule model for LOGN=3 and a modular NTT
// reference for LOGN=10 with a behavioural coefficient memory and butterfly.
`timescale 1ns/1ps
module tb_ntt_stage_controller;
  localparam int     L3   = 3;
  localparam int     N3   = 8;
  localparam int     D3   = 5;
  localparam int     L10  = 10;
  localparam int     N10  = 1024;
  localparam int     MAXC = 160;
  localparam longint Q    = 12289;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ntt_stage_controller_if #(.LOGN(L3))  bus3  ();
  ntt_stage_controller_if #(.LOGN(L10)) bus10 ();

  ntt_stage_controller #(.LOGN(L3), .RD_LATENCY(1), .BF_LATENCY(4)) u_dut3 (
    .clk(clk), .rstn(rstn), .bus(bus3)
  );
  ntt_stage_controller #(.LOGN(L10), .RD_LATENCY(1), .BF_LATENCY(4)) u_dut10 (
    .clk(clk), .rstn(rstn), .bus(bus10)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit stall_v [MAXC];
  int e_rd [MAXC], e_a [MAXC], e_b [MAXC], e_tw [MAXC];
  int e_wr [MAXC], e_wa [MAXC], e_wb [MAXC];
  int e_busy [MAXC], e_done [MAXC], e_stage [MAXC];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero3(input string nm);
    check({nm, " rd_en"},     int'(bus3.rd_en),     0);
    check({nm, " wr_en"},     int'(bus3.wr_en),     0);
    check({nm, " busy"},      int'(bus3.busy),      0);
    check({nm, " done"},      int'(bus3.done),      0);
    check({nm, " stage"},     int'(bus3.stage),     0);
    check({nm, " rd_addr_a"}, int'(bus3.rd_addr_a), 0);
    check({nm, " rd_addr_b"}, int'(bus3.rd_addr_b), 0);
    check({nm, " tw_addr"},   int'(bus3.tw_addr),   0);
    check({nm, " wr_addr_a"}, int'(bus3.wr_addr_a), 0);
    check({nm, " wr_addr_b"}, int'(bus3.wr_addr_b), 0);
  endtask

  // Expected timeline: butterflies enumerated group by group, each waits out stalls,
  // lands D cycles later, and the next stage may only start after the last landing.
  task automatic build_sched(output int done_c);
    int t, last_wr, half, ngrp, s0;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0;
      e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_stage[c] = 0;
    end
    t = 1;
    for (int s = 0; s < L3; s++) begin
      half = 1 << s;
      ngrp = N3 / (2 * half);
      s0   = t;
      for (int g = 0; g < ngrp; g++) begin
        for (int k = 0; k < half; k++) begin
          while (stall_v[t]) t++;
          e_rd[t] = 1;
          e_a[t]  = g * 2 * half + k;
          e_b[t]  = e_a[t] + half;
          e_tw[t] = k * ngrp;
          e_wr[t + D3] = 1;
          e_wa[t + D3] = e_a[t];
          e_wb[t + D3] = e_b[t];
          t++;
        end
      end
      last_wr = t - 1 + D3;
      for (int c = s0; c <= last_wr; c++) begin
        e_busy[c]  = 1;
        e_stage[c] = s;
      end
      t = last_wr + 1;
    end
    e_done[t] = 1;
    done_c = t;
  endtask

  task automatic run3(input string nm, input int rst_at, input bit start_noise,
                      output int obs_done_c, output int obs_s1_rd);
    int done_c, ncyc, ndone;
    string tg;
    build_sched(done_c);
    ncyc = (rst_at >= 0) ? 45 : done_c + 5;
    obs_done_c = -1;
    obs_s1_rd  = -1;
    ndone      = 0;
    for (int c = 0; c < ncyc; c++) begin
      rstn       = (c != rst_at);
      bus3.stall = stall_v[c];
      bus3.start = (c == 0) ||
                   (start_noise && c <= done_c && (c == done_c || $urandom_range(1) == 1));
      @(negedge clk);
      tg = $sformatf("%s c%0d", nm, c);
      if (rst_at >= 0 && c > rst_at) begin
        chk_zero3(tg);
      end else begin
        check({tg, " rd_en"}, int'(bus3.rd_en), e_rd[c]);
        check({tg, " wr_en"}, int'(bus3.wr_en), e_wr[c]);
        check({tg, " busy"},  int'(bus3.busy),  e_busy[c]);
        check({tg, " done"},  int'(bus3.done),  e_done[c]);
        check({tg, " stage"}, int'(bus3.stage), e_stage[c]);
        if (e_rd[c] != 0) begin
          check({tg, " rd_addr_a"}, int'(bus3.rd_addr_a), e_a[c]);
          check({tg, " rd_addr_b"}, int'(bus3.rd_addr_b), e_b[c]);
          check({tg, " tw_addr"},   int'(bus3.tw_addr),   e_tw[c]);
        end
        if (e_wr[c] != 0) begin
          check({tg, " wr_addr_a"}, int'(bus3.wr_addr_a), e_wa[c]);
          check({tg, " wr_addr_b"}, int'(bus3.wr_addr_b), e_wb[c]);
        end
      end
      if (bus3.done) begin
        ndone++;
        if (obs_done_c < 0) obs_done_c = c;
      end
      if (bus3.rd_en && bus3.stage == 2'd1 && obs_s1_rd < 0) obs_s1_rd = c;
      @(posedge clk); #1;
    end
    rstn       = 1'b1;
    bus3.start = 1'b0;
    bus3.stall = 1'b0;
    check({nm, " done count"}, ndone, (rst_at >= 0) ? 0 : 1);
  endtask

  function automatic longint mulmod(input longint a, input longint b);
    return (a * b) % Q;
  endfunction

  function automatic longint powmod(input longint b, input longint e);
    longint r, x, k;
    r = 1; x = b % Q; k = e;
    while (k > 0) begin
      if (k % 2 == 1) r = mulmod(r, x);
      x = mulmod(x, x);
      k = k / 2;
    end
    return r;
  endfunction

  function automatic int bitrev10(input int v);
    int r;
    r = 0;
    for (int i = 0; i < L10; i++) if (v[i]) r = r | (1 << (L10 - 1 - i));
    return r;
  endfunction

  task automatic run_golden();
    longint w, g, t, av, acc;
    longint pw  [N10];
    longint x   [N10];
    longint mem [N10];
    longint qa [$];
    longint qb [$];
    int errs, nwr, ndone, under, c;
    g = 2;
    do begin
      w = powmod(g, (Q - 1) / N10);
      g++;
    end while (powmod(w, N10 / 2) != Q - 1);
    pw[0] = 1;
    for (int i = 1; i < N10; i++) pw[i] = mulmod(pw[i-1], w);
    for (int n = 0; n < N10; n++) begin
      x[n] = longint'($urandom_range(int'(Q) - 1));
      mem[bitrev10(n)] = x[n];
    end
    bus10.stall = 1'b0;
    bus10.start = 1'b1;
    @(posedge clk); #1;
    bus10.start = 1'b0;
    ndone = 0; nwr = 0; under = 0;
    for (c = 1; c < 20000 && ndone == 0; c++) begin
      bus10.stall = ($urandom_range(3) == 0);
      @(negedge clk);
      if (bus10.rd_en) begin
        t  = mulmod(pw[bus10.tw_addr], mem[bus10.rd_addr_b]);
        av = mem[bus10.rd_addr_a];
        qa.push_back((av + t) % Q);
        qb.push_back((av - t + Q) % Q);
      end
      if (bus10.wr_en) begin
        if (qa.size() == 0) under++;
        else begin
          mem[bus10.wr_addr_a] = qa.pop_front();
          mem[bus10.wr_addr_b] = qb.pop_front();
          nwr++;
        end
      end
      if (bus10.done) ndone++;
      @(posedge clk); #1;
    end
    bus10.stall = 1'b0;
    errs = 0;
    for (int k = 0; k < N10; k++) begin
      acc = 0;
      for (int n = 0; n < N10; n++) acc = (acc + mulmod(x[n], pw[(n * k) % N10])) % Q;
      if (acc != mem[k]) errs++;
    end
    check("golden done", ndone, 1);
    check("golden writes", nwr, L10 * N10 / 2);
    check("golden write underflow", under, 0);
    check("golden pending reads", qa.size(), 0);
    check("golden ntt mismatches", errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, s1;
    rstn = 1'b0;
    bus3.start = 1'b0;  bus3.stall = 1'b0;
    bus10.start = 1'b0; bus10.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero3("reset");
    check("reset busy10", int'(bus10.busy), 0);
    check("reset wr_en10", int'(bus10.wr_en), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < MAXC; c++) stall_v[c] = 1'b0;
    run3("base", -1, 1'b0, dc, s1);
    check("base done cycle", dc, 28);
    check("base stage1 first rd", s1, 10);

    stall_v[2] = 1'b1;
    stall_v[3] = 1'b1;
    run3("stall", -1, 1'b0, dc, s1);
    check("stall done cycle", dc, 30);

    for (int c = 0; c < MAXC; c++) stall_v[c] = 1'b0;
    run3("reset_mid", 12, 1'b0, dc, s1);
    run3("rerun", -1, 1'b0, dc, s1);
    check("rerun done cycle", dc, 28);

    run3("start_noise", -1, 1'b1, dc, s1);
    check("start_noise done cycle", dc, 28);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < MAXC; c++) stall_v[c] = (c < 60) && ($urandom_range(3) == 0);
      run3($sformatf("rand%0d", r), -1, r[0], dc, s1);
    end

    run_golden();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ntt_stage_controller.md
Name: ntt_stage_controller

Overview:
- Sequences an in-place iterative Cooley-Tukey NTT over N = 2^LOGN coefficients held in a dual-port coefficient memory.
- Drives one butterfly pipeline, for example ct_butterfly plus its memory read path.
- Generates per-butterfly read addresses, twiddle-ROM address, and delayed write-back addresses.
- Enforces a drain barrier between stages so every read in stage s+1 sees the stage-s writes.

Parameters:
- LOGN, 10, log2 of transform size N; N/2 butterflies per stage, LOGN stages.
- RD_LATENCY, 1, cycles from rd_en to coefficient/twiddle data valid at butterfly inputs.
- BF_LATENCY, 4, cycles from butterfly inputs to A/B outputs.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- stall  in  1  suppress issue of new butterflies; in-flight ops continue
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse when transform complete
- stage  out  $clog2(LOGN)  current stage index
- rd_en  out  1  read coefficients at rd_addr_a/rd_addr_b and twiddle at tw_addr
- rd_addr_a  out  LOGN  index of butterfly input a
- rd_addr_b  out  LOGN  index of butterfly input b
- tw_addr  out  LOGN-1  twiddle ROM index (table of w^i, i = 0..N/2-1)
- wr_en  out  1  write butterfly outputs A to wr_addr_a, B to wr_addr_b
- wr_addr_a  out  LOGN  write-back index for A
- wr_addr_b  out  LOGN  write-back index for B

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn.
- While rstn is low at a clk edge:
  - state <= IDLE; stage and butterfly counter j <= 0.
  - Delay line cleared; in-flight writes are discarded, no wr_en afterwards.
  - All outputs 0.
- Reset mid-transform aborts cleanly, with no done pulse.
- IDLE:
  - start=1 moves to ISSUE with stage=0, j=0.
  - start is ignored in all other states.
- ISSUE: each cycle with stall=0:
  - rd_en=1 and j increments.
  - Addresses, with s = stage, half = 2^s, g = j>>s, k = j & (half-1):
    - rd_addr_a = (g<<(s+1)) | k
    - rd_addr_b = rd_addr_a + half
    - tw_addr = k<<(LOGN-1-s)
  - When stall=1: rd_en=0 and j holds. rd_* address values are don't-care but must not cause a write.
  - After the issue with j = N/2-1, go to DRAIN with j <= 0.
- Delay line: D = RD_LATENCY + BF_LATENCY stages, each carrying {valid, rd_addr_a, rd_addr_b}.
  - wr_en and wr_addr_* equal the rd_en and rd_addr_* values from exactly D cycles earlier.
  - The delay line is unaffected by stall.
- DRAIN: stay until the cycle after the final wr_en of the stage (delay line empty). Then:
  - if stage == LOGN-1, go to DONE;
  - else stage++ and go to ISSUE.
  - The first read of the next stage is therefore at least 1 cycle after the last write of the previous stage.
- DONE: done=1 for one cycle, busy=0, then IDLE.
  - start in the DONE cycle is ignored; a new transform needs start in IDLE.
- Timing with no stall, start sampled at cycle 0:
  - first rd_en at cycle 1;
  - per-stage period N/2 + D cycles;
  - done asserted at cycle LOGN*(N/2+D) + 1.
- Stall timing: every stall cycle during ISSUE adds exactly one cycle. stall in DRAIN, IDLE or DONE has no effect.
- stage output holds its value through DRAIN and is 0 in IDLE.

Test Plan:
- Stage address sequence (LOGN=3, RD_LATENCY=1, BF_LATENCY=4, start at cycle 0, no stall). Required (a,b,tw) per stage:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Same configuration, write-back timing:
  - wr_en at cycles 6-9, 15-18 and 24-27 with the addresses above;
  - next stage's first rd_en at cycles 10 and 19;
  - done pulse at cycle 28; busy high during cycles 1-27.
- Stall: stall=1 during cycles 2-3 of stage 0:
  - issues occur at cycles 1, 4, 5, 6 with no skipped or duplicated j;
  - done at cycle 30.
- Reset mid-operation: rstn=0 at cycle 12 for one cycle:
  - outputs 0 from cycle 13;
  - no wr_en after the reset;
  - no done;
  - a subsequent start reproduces the first scenario exactly.
- Start handling: start pulses while busy and during the DONE cycle are ignored; a single transform completes with exactly one done.
- Golden model: with the butterfly replaced by a modular Cooley-Tukey model and memory initialised bit-reversed, LOGN=10 output matches the software NTT for a random input.
